// File: rtl/game_controller_if.sv
// game_controller_if: frame/start/miss events into the pong sequencer and its registered status back out
interface game_controller_if #(parameter int SCORE_W = 4);
   logic new_frame_i, start_i, miss_left_i, miss_right_i;
   logic run_o, serve_o, serve_dir_o, blink_o, blink_sel_o, game_over_o;
   logic [SCORE_W-1:0] score_left_o, score_right_o;
   logic [2:0] state_o;
   modport master (
      output new_frame_i, start_i, miss_left_i, miss_right_i,
      input run_o, serve_o, serve_dir_o, blink_o, blink_sel_o, game_over_o, score_left_o, score_right_o, state_o
   );
   modport slave (
      input new_frame_i, start_i, miss_left_i, miss_right_i,
      output run_o, serve_o, serve_dir_o, blink_o, blink_sel_o, game_over_o, score_left_o, score_right_o, state_o
   );
endinterface

// File: rtl/game_controller.sv
// game_controller: pong game sequencer owning serve timing, scores, score blink and game-over
module game_controller #(
   parameter int SCORE_W = 4,
   parameter int WIN_SCORE = 9,
   parameter int SERVE_FRAMES = 60,
   parameter int POINT_FRAMES = 90,
   parameter int BLINK_FRAMES = 8,
   parameter int CNT_W = 8
) (
   input logic clk_i,
   input logic rst_i,
   game_controller_if.slave bus
);
   localparam logic [CNT_W-1:0] SERVE_LD = CNT_W'(SERVE_FRAMES == 0 ? 1 : SERVE_FRAMES);
   localparam logic [CNT_W-1:0] POINT_LD = CNT_W'(POINT_FRAMES == 0 ? 1 : POINT_FRAMES);
   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
   localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [BW-1:0] PH_LAST = BW'(BLINK_FRAMES - 1);
   localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
   typedef enum logic [2:0] {IDLE = 3'd0, SERVE = 3'd1, PLAY = 3'd2, POINT = 3'd3, OVER = 3'd4} state_t;
   state_t state, state_n;
   logic [CNT_W-1:0] cnt, cnt_n;
   logic [SCORE_W-1:0] sl, sl_n, sr, sr_n;
   logic [BW-1:0] ph, ph_n;
   logic dir, dir_n, sel, sel_n, blink, blink_n, serve, serve_n, run, go;
   logic miss, restart, frame_last;
   assign miss = bus.miss_left_i | bus.miss_right_i;
   assign frame_last = bus.new_frame_i && cnt <= ONE;
   assign restart = bus.start_i && (state == IDLE || state == OVER);
   always_comb begin
      state_n = state;
      cnt_n = cnt;
      sl_n = sl;
      sr_n = sr;
      ph_n = ph;
      dir_n = dir;
      sel_n = sel;
      blink_n = blink;
      serve_n = 1'b0;
      unique case (state)
         SERVE: begin
            cnt_n = bus.new_frame_i ? cnt - ONE : cnt;
            serve_n = frame_last;
            state_n = frame_last ? PLAY : SERVE;
         end
         PLAY: begin
            if (bus.miss_left_i && bus.miss_right_i) begin
               cnt_n = SERVE_LD;
               state_n = SERVE;
            end else if (miss) begin
               sr_n = sr + SCORE_W'(bus.miss_left_i);
               sl_n = sl + SCORE_W'(bus.miss_right_i);
               sel_n = bus.miss_left_i;
               dir_n = bus.miss_right_i;
               blink_n = 1'b1;
               ph_n = '0;
               cnt_n = POINT_LD;
               state_n = (sr_n == WIN || sl_n == WIN) ? OVER : POINT;
            end
         end
         POINT, OVER: begin
            // blink phase advances per frame; the score hides/shows once per BLINK_FRAMES frames
            if (bus.new_frame_i) begin
               ph_n = (ph == PH_LAST) ? '0 : ph + 1'b1;
               blink_n = blink ^ (ph == PH_LAST);
            end
            if (state == POINT && bus.new_frame_i) begin
               cnt_n = frame_last ? SERVE_LD : cnt - ONE;
               blink_n = frame_last ? 1'b0 : blink_n;
               state_n = frame_last ? SERVE : POINT;
            end
         end
         default: state_n = IDLE;
      endcase
      if (restart) begin
         sl_n = '0;
         sr_n = '0;
         dir_n = 1'b1;
         blink_n = 1'b0;
         cnt_n = SERVE_LD;
         state_n = SERVE;
      end
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt <= '0;
         sl <= '0;
         sr <= '0;
         ph <= '0;
         dir <= 1'b0;
         sel <= 1'b0;
         blink <= 1'b0;
         serve <= 1'b0;
         run <= 1'b0;
         go <= 1'b0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
         sl <= sl_n;
         sr <= sr_n;
         ph <= ph_n;
         dir <= dir_n;
         sel <= sel_n;
         blink <= blink_n;
         serve <= serve_n;
         run <= state_n == PLAY;
         go <= state_n == OVER;
      end
   end
   assign bus.run_o = run;
   assign bus.serve_o = serve;
   assign bus.serve_dir_o = dir;
   assign bus.score_left_o = sl;
   assign bus.score_right_o = sr;
   assign bus.blink_o = blink;
   assign bus.blink_sel_o = sel;
   assign bus.game_over_o = go;
   assign bus.state_o = state;
endmodule

// File: tb/tb_game_controller.sv
// tb_game_controller: directed plan plus random play on two configurations, checked against a frame-counting model
module tb_game_controller;
   logic clk = 0, rst = 1, st = 0, nf = 0, ml = 0, mr = 0;
   int total = 0, bad = 0;
   bit ready = 0;
   always #5 clk = ~clk;
   game_controller_if #(.SCORE_W(4)) a ();
   game_controller_if #(.SCORE_W(4)) b ();
   assign a.start_i = st;
   assign a.new_frame_i = nf;
   assign a.miss_left_i = ml;
   assign a.miss_right_i = mr;
   assign b.start_i = st;
   assign b.new_frame_i = nf;
   assign b.miss_left_i = ml;
   assign b.miss_right_i = mr;
   game_controller #(.SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(3), .POINT_FRAMES(4), .BLINK_FRAMES(2), .CNT_W(8))
      dut (.clk_i(clk), .rst_i(rst), .bus(a.slave));
   game_controller #(.SCORE_W(4), .WIN_SCORE(3), .SERVE_FRAMES(0), .POINT_FRAMES(4), .BLINK_FRAMES(2), .CNT_W(8))
      dut0 (.clk_i(clk), .rst_i(rst), .bus(b.slave));
   // model: mode 0..4 = idle/serve/play/point/over, blink derived from frames seen since the point
   localparam int W = 3, PF = 4, BF = 2;
   int sfe [2] = '{3, 1};
   int m_mode [2], m_left [2], m_nb [2], m_sl [2], m_sr [2];
   bit m_serve [2], m_dir [2], m_sel [2];
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         m_serve[k] = 0;
         if (rst) begin
            m_mode[k] = 0; m_left[k] = 0; m_nb[k] = 0; m_sl[k] = 0; m_sr[k] = 0; m_dir[k] = 0; m_sel[k] = 0;
         end else if ((m_mode[k] == 0 || m_mode[k] == 4) && st) begin
            m_sl[k] = 0; m_sr[k] = 0; m_dir[k] = 1; m_left[k] = sfe[k]; m_mode[k] = 1;
         end else if (m_mode[k] == 4 && nf) begin
            m_nb[k]++;
         end else if (m_mode[k] == 1 && nf) begin
            m_left[k]--;
            if (m_left[k] == 0) begin m_serve[k] = 1; m_mode[k] = 2; end
         end else if (m_mode[k] == 2 && ml && mr) begin
            m_left[k] = sfe[k]; m_mode[k] = 1;
         end else if (m_mode[k] == 2 && (ml || mr)) begin
            if (ml) m_sr[k]++; else m_sl[k]++;
            m_sel[k] = ml; m_dir[k] = mr; m_nb[k] = 0; m_left[k] = PF;
            m_mode[k] = (m_sl[k] == W || m_sr[k] == W) ? 4 : 3;
         end else if (m_mode[k] == 3 && nf) begin
            m_nb[k]++; m_left[k]--;
            if (m_left[k] == 0) begin m_left[k] = sfe[k]; m_mode[k] = 1; end
         end
      end
      if (rst) ready = 1;
   end
   task automatic chk(input string n, input int k, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s dut%0d t=%0t got=%0d want=%0d", n, k, $time, got, want);
      end
   endtask
   task automatic cmp(input int k, input logic [2:0] s, input logic run, sv, dir, input logic [3:0] sl, sr,
                      input logic bl, sel, go);
      chk("state", k, s, m_mode[k]);
      chk("run", k, run, m_mode[k] == 2);
      chk("serve", k, sv, m_serve[k]);
      chk("serve_dir", k, dir, m_dir[k]);
      chk("score_left", k, sl, m_sl[k]);
      chk("score_right", k, sr, m_sr[k]);
      chk("blink", k, bl, (m_mode[k] == 3 || m_mode[k] == 4) && (m_nb[k] / BF) % 2 == 0);
      chk("blink_sel", k, sel, m_sel[k]);
      chk("game_over", k, go, m_mode[k] == 4);
   endtask
   always @(negedge clk) if (ready) begin
      cmp(0, a.state_o, a.run_o, a.serve_o, a.serve_dir_o, a.score_left_o, a.score_right_o, a.blink_o, a.blink_sel_o, a.game_over_o);
      cmp(1, b.state_o, b.run_o, b.serve_o, b.serve_dir_o, b.score_left_o, b.score_right_o, b.blink_o, b.blink_sel_o, b.game_over_o);
   end
   task automatic cyc(input logic s, f, l, r, x);
      st = s; nf = f; ml = l; mr = r; rst = x;
      @(negedge clk);
      st = 0; nf = 0; ml = 0; mr = 0; rst = 0;
   endtask
   task automatic frames(input int n);
      repeat (n) begin cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 0); end
   endtask
   initial begin
      cyc(0, 0, 0, 0, 1);
      cyc(0, 0, 0, 0, 1);
      chk("rst_state", 0, a.state_o, 0);
      chk("rst_run", 0, a.run_o, 0);
      chk("rst_score", 0, a.score_left_o, 0);
      cyc(1, 0, 0, 0, 0);
      chk("start_state", 0, a.state_o, 1);
      cyc(0, 1, 0, 0, 0);
      chk("sf0_serve", 1, b.serve_o, 1);
      chk("sf0_state", 1, b.state_o, 2);
      cyc(0, 0, 0, 0, 0);
      chk("sf0_serve_end", 1, b.serve_o, 0);
      cyc(0, 1, 0, 0, 0);
      chk("pre_serve", 0, a.serve_o, 0);
      cyc(0, 1, 0, 0, 0);
      chk("serve_pulse", 0, a.serve_o, 1);
      chk("serve_dir", 0, a.serve_dir_o, 1);
      chk("serve_run", 0, a.run_o, 1);
      chk("serve_state", 0, a.state_o, 2);
      cyc(0, 0, 0, 0, 0);
      chk("serve_one_cycle", 0, a.serve_o, 0);
      cyc(1, 0, 0, 0, 0);
      chk("start_in_play", 0, a.state_o, 2);
      cyc(0, 0, 0, 1, 0);
      chk("pt_score_left", 0, a.score_left_o, 1);
      chk("pt_sel", 0, a.blink_sel_o, 0);
      chk("pt_state", 0, a.state_o, 3);
      cyc(0, 0, 1, 0, 0);
      chk("miss_in_point", 0, a.score_right_o, 0);
      frames(3);
      chk("point_hold", 0, a.state_o, 3);
      frames(1);
      chk("point_exit", 0, a.state_o, 1);
      cyc(0, 0, 1, 0, 0);
      chk("miss_in_serve", 0, a.score_right_o, 0);
      frames(2);
      cyc(0, 1, 0, 0, 0);
      chk("reserve", 0, a.serve_o, 1);
      for (int p = 1; p <= 3; p++) begin
         cyc(0, 0, 1, 0, 0);
         chk("score_right", 0, a.score_right_o, p);
         if (p < 3) begin
            chk("dir_left", 0, a.serve_dir_o, 0);
            frames(4);
            frames(3);
         end
      end
      chk("over", 0, a.game_over_o, 1);
      chk("over_run", 0, a.run_o, 0);
      chk("over_state", 0, a.state_o, 4);
      chk("blink0", 0, a.blink_o, 1);
      cyc(0, 1, 0, 0, 0); chk("blink1", 0, a.blink_o, 1);
      cyc(0, 1, 0, 0, 0); chk("blink2", 0, a.blink_o, 0);
      cyc(0, 1, 0, 0, 0); chk("blink3", 0, a.blink_o, 0);
      cyc(0, 1, 0, 0, 0); chk("blink4", 0, a.blink_o, 1);
      cyc(1, 0, 0, 0, 0);
      chk("restart_score", 0, a.score_right_o, 0);
      chk("restart_state", 0, a.state_o, 1);
      frames(3);
      cyc(0, 0, 1, 1, 0);
      chk("double_miss_state", 0, a.state_o, 1);
      chk("double_miss_score", 0, a.score_left_o, 0);
      frames(3);
      cyc(0, 0, 1, 0, 0);
      chk("pt_again", 0, a.state_o, 3);
      cyc(0, 0, 0, 0, 1);
      chk("mid_rst_state", 0, a.state_o, 0);
      chk("mid_rst_score", 0, a.score_right_o, 0);
      chk("mid_rst_blink", 0, a.blink_o, 0);
      cyc(0, 0, 1, 0, 0);
      chk("miss_in_idle", 0, a.score_right_o, 0);
      repeat (4000)
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
             $urandom_range(0, 15) == 0, $urandom_range(0, 599) == 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/game_controller.md
Name: game_controller

Overview:
- Top-level game sequencer for pong; sits between the per-frame game logic and the display path.
- Consumes the one-cycle new-frame strobe from the display block and ball-miss events from the ball/collision logic.
- Decides when the ball runs, when it is served and in which direction, and when the game ends.
- Owns both score registers, plus the score-blink control the score display uses.

Parameters:
- SCORE_W, 4, width of each score register.
- WIN_SCORE, 9, score that ends the game; must be < 2**SCORE_W.
- SERVE_FRAMES, 60, frames the ball is frozen before a serve.
- POINT_FRAMES, 90, frames the post-point pause lasts.
- BLINK_FRAMES, 8, frames per blink half-period; power of two.
- CNT_W, 8, frame-counter width; must hold max(SERVE_FRAMES, POINT_FRAMES).

Ports:
- clk_i  in  1  system/pixel clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- new_frame_i  in  1  one-cycle pulse per frame, from the display block.
- start_i  in  1  one-cycle start request, debounced upstream.
- miss_left_i  in  1  one-cycle pulse: ball passed the left paddle.
- miss_right_i  in  1  one-cycle pulse: ball passed the right paddle.
- run_o  out  1  ball/paddle motion enable.
- serve_o  out  1  one-cycle pulse: ball logic recentres and launches the ball.
- serve_dir_o  out  1  launch direction: 0 = toward left, 1 = toward right.
- score_left_o  out  SCORE_W  left player score.
- score_right_o  out  SCORE_W  right player score.
- blink_o  out  1  1 = hide the blinking score this frame.
- blink_sel_o  out  1  score that blinks: 0 = left, 1 = right.
- game_over_o  out  1  high while in GAME_OVER.
- state_o  out  3  encoded state, for debug/LEDs.

Behaviour:
- One clock, clk_i. Reset is synchronous and active-high on rst_i.
- All outputs are registered. Output effects appear one cycle after the triggering input cycle.
- Reset values:
  - state = IDLE (state_o = 0);
  - run_o, serve_o, serve_dir_o, blink_o, blink_sel_o, game_over_o = 0;
  - both scores = 0; frame counter = 0.
- Reset asserted mid-game abandons all state on the next edge.
- State encoding: IDLE = 0, SERVE = 1, PLAY = 2, POINT = 3, OVER = 4.
- IDLE:
  - run_o = 0.
  - start_i: clear scores, set serve_dir_o = 1, load counter = SERVE_FRAMES, go to SERVE.
- SERVE:
  - run_o = 0.
  - Each new_frame_i decrements the counter.
  - A new_frame_i while counter == 1 pulses serve_o for exactly one cycle and enters PLAY; run_o rises in the same cycle as serve_o.
  - SERVE_FRAMES = 0 is treated as 1.
- PLAY:
  - run_o = 1.
  - miss_left_i alone: score_right += 1, blink_sel_o = 1, serve_dir_o = 0 (serve toward the conceding player).
  - miss_right_i alone: score_left += 1, blink_sel_o = 0, serve_dir_o = 1.
  - After a score, if the new score == WIN_SCORE go to OVER; otherwise load counter = POINT_FRAMES and go to POINT.
  - Both misses in the same cycle: no score change, serve_dir_o unchanged, load SERVE_FRAMES, go to SERVE.
- POINT:
  - run_o = 0.
  - blink_o toggles every BLINK_FRAMES new_frame_i pulses, starting at 1.
  - Counter decrements on new_frame_i; at counter == 1 with new_frame_i, load SERVE_FRAMES, clear blink_o, go to SERVE.
- OVER:
  - run_o = 0, game_over_o = 1.
  - blink_o toggles as in POINT, indefinitely.
  - start_i: clear scores and blink_o, set serve_dir_o = 1, load SERVE_FRAMES, go to SERVE.
- Input filtering:
  - start_i is ignored outside IDLE and OVER.
  - Miss pulses are ignored outside PLAY.
  - new_frame_i has no effect in IDLE or PLAY.
- A miss coincident with new_frame_i in PLAY: the miss is handled and the frame pulse is ignored.
- Score arithmetic is unsigned and never exceeds WIN_SCORE, so no wrap is possible.
- The blink phase counter is clear on entry to POINT/OVER.

Test Plan:
- Params for all scenarios except the last: SERVE_FRAMES = 3, POINT_FRAMES = 4, BLINK_FRAMES = 2, WIN_SCORE = 3.
- Reset, start_i, then 3 new_frame_i pulses -> serve_o high exactly 1 cycle after the 3rd pulse; serve_dir_o = 1; run_o = 1 from that cycle; state_o = 2.
- In PLAY, miss_right_i -> score_left_o = 1, blink_sel_o = 0, serve_dir_o = 1, state_o = 3. Then 4 frames -> state_o = 1; 3 more frames -> serve_o pulse.
- Three miss_left_i points -> score_right_o = 3, game_over_o = 1, run_o = 0. blink_o sequence over frames: 1,1,0,0,1. start_i -> scores = 0, state_o = 1.
- Miss pulses in SERVE/POINT/IDLE, and start_i in PLAY -> no score or state change.
- miss_left_i and miss_right_i in the same cycle -> scores unchanged, state_o = 1. Separately, rst_i asserted in POINT -> all outputs at reset values on the next cycle.
- SERVE_FRAMES = 0 -> serve on the first new_frame_i after start_i.
